// File: rtl/tqv_periph_bus_arbiter_pkg.sv
// Shared TinyQV peripheral-bus definitions: transaction widths, arbiter FSM states,
// and the read-data width mask.
package tqv_bus_pkg;

    localparam logic [1:0] TXN_BYTE = 2'b00;
    localparam logic [1:0] TXN_HALF = 2'b01;
    localparam logic [1:0] TXN_WORD = 2'b10;
    localparam logic [1:0] TXN_NONE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    function automatic logic [31:0] mask_rdata(input logic [1:0] txn, input logic [31:0] data);
        case (txn)
            TXN_BYTE: return {24'd0, data[7:0]};
            TXN_HALF: return {16'd0, data[15:0]};
            default:  return data;
        endcase
    endfunction

endpackage

// File: rtl/tqv_periph_bus_arbiter_rr_arb2.sv
// Two-way round-robin picker, purely combinational: a lone requester always wins,
// and on a tie the requester named by ptr (0 = m0, 1 = m1) wins.
module tqv_rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = ptr ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/tqv_periph_bus_arbiter.sv
// Serialises m0/m1 single transactions onto the TinyQV peripheral bus; accept->strobe 1 cycle,
// resp 2 cycles after accept plus read wait cycles; losing requester waits with valid held.
module tqv_periph_bus_arbiter
    import tqv_bus_pkg::*;
#(
    parameter int ADDR_W  = 6,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_valid,
    input  logic              m0_write,
    input  logic [1:0]        m0_txn,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [31:0]       m0_wdata,
    output logic              m0_ready,
    output logic              m0_resp_valid,
    output logic [31:0]       m0_rdata,
    output logic              m0_err,
    input  logic              m1_valid,
    input  logic              m1_write,
    input  logic [1:0]        m1_txn,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [31:0]       m1_wdata,
    output logic              m1_ready,
    output logic              m1_resp_valid,
    output logic [31:0]       m1_rdata,
    output logic              m1_err,
    output logic [ADDR_W-1:0] address,
    output logic [31:0]       data_in,
    output logic [1:0]        data_write_n,
    output logic [1:0]        data_read_n,
    input  logic [31:0]       data_out,
    input  logic              data_ready
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

    state_t              r_state;
    logic                r_gnt;
    logic                r_ptr;
    logic [1:0]          r_txn;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic [31:0]         r_rdata;
    logic                r_err;
    logic [CNT_W-1:0]    r_cnt;

    logic [1:0]          w_req;
    logic [1:0]          w_gnt;
    logic                w_accept;
    logic                w_sel;
    logic                w_sel_write;
    logic [1:0]          w_sel_txn;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [31:0]         w_sel_wdata;
    logic [CNT_W-1:0]    w_cnt_inc;
    logic                w_timeout;
    logic                w_resp;

    assign w_req = {m1_valid, m0_valid};

    tqv_rr_arb2 u_arb (
        .req (w_req),
        .ptr (r_ptr),
        .gnt (w_gnt)
    );

    assign w_accept    = (r_state == ST_IDLE) && (w_req != 2'b00);
    assign w_sel       = w_gnt[1];
    assign w_sel_write = w_sel ? m1_write : m0_write;
    assign w_sel_txn   = w_sel ? m1_txn   : m0_txn;
    assign w_sel_addr  = w_sel ? m1_addr  : m0_addr;
    assign w_sel_wdata = w_sel ? m1_wdata : m0_wdata;

    // A zero TIMEOUT disables the limit; the counter then just wraps harmlessly.
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_timeout = (TIMEOUT != 0) && (w_cnt_inc == CNT_LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_gnt   <= 1'b0;
            r_ptr   <= 1'b0;
            r_txn   <= TXN_BYTE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_gnt   <= w_sel;
                        r_txn   <= w_sel_txn;
                        r_addr  <= w_sel_addr;
                        r_wdata <= w_sel_wdata;
                        r_rdata <= '0;
                        r_err   <= (w_sel_txn == TXN_NONE);
                        r_cnt   <= '0;
                        if (w_sel_txn == TXN_NONE) begin
                            r_state <= ST_RESP;
                        end else if (w_sel_write) begin
                            r_state <= ST_WRITE;
                        end else begin
                            r_state <= ST_READ;
                        end
                    end
                end
                ST_WRITE: r_state <= ST_RESP;
                ST_READ: begin
                    // data_ready wins over an expiring counter in the same cycle.
                    if (data_ready) begin
                        r_rdata <= mask_rdata(r_txn, data_out);
                        r_state <= ST_RESP;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                ST_RESP: begin
                    r_ptr   <= ~r_gnt;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_resp = (r_state == ST_RESP);

    assign m0_ready      = w_accept & w_gnt[0];
    assign m1_ready      = w_accept & w_gnt[1];
    assign m0_resp_valid = w_resp & ~r_gnt;
    assign m1_resp_valid = w_resp & r_gnt;
    assign m0_rdata      = m0_resp_valid ? r_rdata : 32'd0;
    assign m1_rdata      = m1_resp_valid ? r_rdata : 32'd0;
    assign m0_err        = m0_resp_valid & r_err;
    assign m1_err        = m1_resp_valid & r_err;

    assign address      = r_addr;
    assign data_in      = r_wdata;
    assign data_write_n = (r_state == ST_WRITE) ? r_txn : 2'b11;
    assign data_read_n  = (r_state == ST_READ)  ? r_txn : 2'b11;

endmodule

// File: tb/tb_tqv_periph_bus_arbiter.sv
// Bench for tqv_periph_bus_arbiter: directed vector table, fairness and reset-abort
// sequences, then randomized traffic from both masters against a transaction-level model.
module tb_tqv_periph_bus_arbiter;

    localparam int TIMEOUT = 8;

    logic        clk;
    logic        rst;
    logic        m0_valid, m0_write, m0_ready, m0_resp_valid, m0_err;
    logic [1:0]  m0_txn;
    logic [5:0]  m0_addr;
    logic [31:0] m0_wdata, m0_rdata;
    logic        m1_valid, m1_write, m1_ready, m1_resp_valid, m1_err;
    logic [1:0]  m1_txn;
    logic [5:0]  m1_addr;
    logic [31:0] m1_wdata, m1_rdata;
    logic [5:0]  address;
    logic [31:0] data_in, data_out;
    logic [1:0]  data_write_n, data_read_n;
    logic        data_ready;

    tqv_periph_bus_arbiter #(.ADDR_W(6), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .m0_valid(m0_valid), .m0_write(m0_write), .m0_txn(m0_txn), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_ready(m0_ready), .m0_resp_valid(m0_resp_valid),
        .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_valid(m1_valid), .m1_write(m1_write), .m1_txn(m1_txn), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_ready(m1_ready), .m1_resp_valid(m1_resp_valid),
        .m1_rdata(m1_rdata), .m1_err(m1_err),
        .address(address), .data_in(data_in), .data_write_n(data_write_n),
        .data_read_n(data_read_n), .data_out(data_out), .data_ready(data_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Peripheral model: per-address read data and wait count; noise on data_ready when idle.
    logic [31:0] mem [64];
    int          rd_wait [64];
    int          per_cnt;
    logic        noise = 1'b0;

    always @(posedge clk) noise <= ~noise;
    always @(posedge clk or posedge rst) begin
        if (rst) per_cnt <= 0;
        else if (data_read_n != 2'b11) per_cnt <= per_cnt + 1;
        else per_cnt <= 0;
    end
    assign data_ready = (data_read_n != 2'b11) ? (per_cnt >= rd_wait[address]) : noise;
    assign data_out   = (data_read_n != 2'b11) ? mem[address] : 32'hDEAD_BEEF;

    // Bus monitor: strobe cycle counts per transaction, last write seen, grant log.
    int          overlap = 0, dual_rdy = 0, wr_cyc = 0, rd_cyc = 0, exp_ptr = 0;
    logic [5:0]  lw_addr;
    logic [31:0] lw_data;
    logic [1:0]  lw_txn;
    int          g_act[$];
    int          g_exp[$];

    always @(negedge clk) begin
        if (rst) begin
            exp_ptr = 0;
            wr_cyc  = 0;
            rd_cyc  = 0;
        end else begin
            if (data_write_n != 2'b11 && data_read_n != 2'b11) overlap++;
            if (data_write_n != 2'b11) begin
                wr_cyc++;
                lw_addr = address;
                lw_data = data_in;
                lw_txn  = data_write_n;
            end
            if (data_read_n != 2'b11) rd_cyc++;
            if (m0_ready && m1_ready) dual_rdy++;
            if (m0_ready || m1_ready) begin
                g_act.push_back(m1_ready ? 1 : 0);
                g_exp.push_back((m0_valid && m1_valid) ? exp_ptr : (m1_valid ? 1 : 0));
                wr_cyc = 0;
                rd_cyc = 0;
            end
            if (m0_resp_valid) exp_ptr = 1;
            if (m1_resp_valid) exp_ptr = 0;
        end
    end

    int checks = 0, errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input int m, input bit v, input bit wr, input logic [1:0] txn,
                         input logic [5:0] addr, input logic [31:0] wd);
        if (m == 0) begin
            m0_valid = v; m0_write = wr; m0_txn = txn; m0_addr = addr; m0_wdata = wd;
        end else begin
            m1_valid = v; m1_write = wr; m1_txn = txn; m1_addr = addr; m1_wdata = wd;
        end
    endtask

    function automatic bit rdy(input int m);
        return (m == 0) ? m0_ready : m1_ready;
    endfunction

    function automatic bit rsp(input int m);
        return (m == 0) ? m0_resp_valid : m1_resp_valid;
    endfunction

    // Starts and ends at posedge+1. lat = cycles from accept to resp_valid.
    task automatic do_txn(input int m, input bit wr, input logic [1:0] txn, input logic [5:0] addr,
                          input logic [31:0] wd, output logic [31:0] rdata, output bit err,
                          output int lat, output bit to);
        int n;
        to = 0; rdata = 0; err = 0; lat = 0; n = 0;
        drive(m, 1'b1, wr, txn, addr, wd);
        forever begin
            @(negedge clk);
            if (rdy(m)) break;
            n++;
            if (n > 300) begin to = 1; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        drive(m, 1'b0, wr, txn, addr, wd);
        if (!to) begin
            forever begin
                @(negedge clk);
                lat++;
                if (rsp(m)) begin
                    rdata = (m == 0) ? m0_rdata : m1_rdata;
                    err   = (m == 0) ? m0_err : m1_err;
                    break;
                end
                if (lat > 50) begin to = 1; break; end
            end
            @(posedge clk); #1;
        end
    endtask

    // Transaction-level expectation straight from the bus rules.
    task automatic model(input bit wr, input logic [1:0] txn, input logic [5:0] addr,
                         output logic [31:0] rd, output bit err, output int lat,
                         output int wc, output int rc);
        logic [63:0] modv;
        rd = 0; err = 0; wc = 0; rc = 0;
        if (txn == 2'b11) begin
            err = 1; lat = 1;
        end else if (wr) begin
            lat = 2; wc = 1;
        end else if (rd_wait[addr] >= TIMEOUT) begin
            err = 1; lat = TIMEOUT + 1; rc = TIMEOUT;
        end else begin
            modv = 64'd1 << (8 << txn);
            rd   = 32'({32'd0, mem[addr]} % modv);
            lat  = rd_wait[addr] + 2;
            rc   = rd_wait[addr] + 1;
        end
    endtask

    typedef struct {
        int          m;
        bit          wr;
        logic [1:0]  txn;
        logic [5:0]  addr;
        logic [31:0] wdata;
        logic [31:0] pdata;
        int          pwait;
        logic [31:0] e_rdata;
        bit          e_err;
        int          e_lat;
        int          e_wr;
        int          e_rd;
    } vec_t;

    vec_t tbl [8];

    task automatic run_and_check(input string tag, input int m, input bit wr, input logic [1:0] txn,
                                 input logic [5:0] addr, input logic [31:0] wd,
                                 input logic [31:0] e_rd, input bit e_err, input int e_lat,
                                 input int e_wc, input int e_rc);
        logic [31:0] rd;
        bit          err, to;
        int          lat;
        do_txn(m, wr, txn, addr, wd, rd, err, lat, to);
        check({tag, "_timeout"}, to, 0);
        check({tag, "_rdata"}, rd, e_rd);
        check({tag, "_err"}, err, e_err);
        check({tag, "_lat"}, lat, e_lat);
        check({tag, "_wr_cycles"}, wr_cyc, e_wc);
        check({tag, "_rd_cycles"}, rd_cyc, e_rc);
        if (e_wc == 1) check({tag, "_bus_write"}, {lw_addr, lw_data, lw_txn}, {addr, wd, txn});
    endtask

    initial begin
        logic [31:0] e_rd;
        bit          e_err;
        int          e_lat, e_wc, e_rc, n, base, respcnt;

        rst = 1'b1;
        drive(0, 0, 0, 2'b00, 6'h00, 32'h0);
        drive(1, 0, 0, 2'b00, 6'h00, 32'h0);
        for (int i = 0; i < 64; i++) begin mem[i] = $urandom; rd_wait[i] = 0; end

        tbl[0] = '{0, 1'b1, 2'b10, 6'h05, 32'hA5A5_1234, 32'h0,         0,  32'h0,         1'b0, 2, 1, 0};
        tbl[1] = '{1, 1'b0, 2'b00, 6'h10, 32'h0,         32'h1234_56F0, 3,  32'h0000_00F0, 1'b0, 5, 0, 4};
        tbl[2] = '{0, 1'b0, 2'b01, 6'h11, 32'h0,         32'hCAFE_BABE, 0,  32'h0000_BABE, 1'b0, 2, 0, 1};
        tbl[3] = '{1, 1'b0, 2'b10, 6'h12, 32'h0,         32'h89AB_CDEF, 7,  32'h89AB_CDEF, 1'b0, 9, 0, 8};
        tbl[4] = '{0, 1'b0, 2'b10, 6'h13, 32'h0,         32'h55AA_55AA, 20, 32'h0,         1'b1, 9, 0, 8};
        tbl[5] = '{1, 1'b1, 2'b11, 6'h20, 32'h1111_1111, 32'h0,         0,  32'h0,         1'b1, 1, 0, 0};
        tbl[6] = '{0, 1'b0, 2'b11, 6'h21, 32'h0,         32'h7777_7777, 0,  32'h0,         1'b1, 1, 0, 0};
        tbl[7] = '{1, 1'b1, 2'b00, 6'h3F, 32'hFFFF_FF77, 32'h0,         0,  32'h0,         1'b0, 2, 1, 0};

        repeat (2) @(posedge clk);
        #1;
        check("rst_address", address, 0);
        check("rst_data_in", data_in, 0);
        check("rst_write_n", data_write_n, 2'b11);
        check("rst_read_n", data_read_n, 2'b11);
        check("rst_ready", {m0_ready, m1_ready}, 0);
        check("rst_resp", {m0_resp_valid, m1_resp_valid, m0_err, m1_err}, 0);
        check("rst_rdata", {m0_rdata, m1_rdata}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            mem[tbl[i].addr]     = tbl[i].pdata;
            rd_wait[tbl[i].addr] = tbl[i].pwait;
            run_and_check($sformatf("vec%0d", i), tbl[i].m, tbl[i].wr, tbl[i].txn, tbl[i].addr,
                          tbl[i].wdata, tbl[i].e_rdata, tbl[i].e_err, tbl[i].e_lat,
                          tbl[i].e_wr, tbl[i].e_rd);
        end

        // Simultaneous requests twice: last table entry was m1, so m0 leads.
        base = g_act.size();
        for (int k = 0; k < 2; k++) begin
            fork
                begin
                    logic [31:0] r0; bit e0, t0; int l0;
                    do_txn(0, 1'b1, 2'b10, 6'h01, 32'h0000_0A00 + k, r0, e0, l0, t0);
                    check("fair_m0_lat", l0, 2);
                end
                begin
                    logic [31:0] r1; bit e1, t1; int l1;
                    do_txn(1, 1'b1, 2'b10, 6'h02, 32'h0000_0B00 + k, r1, e1, l1, t1);
                    check("fair_m1_lat", l1, 2);
                end
            join
        end
        check("fair_count", g_act.size() - base, 4);
        for (int k = 0; k < 4 && base + k < g_act.size(); k++)
            check($sformatf("fair_order%0d", k), g_act[base + k], k % 2);

        // Reset in the middle of a read wait.
        mem[6'h30] = 32'h0F0F_0F0F;
        rd_wait[6'h30] = 20;
        drive(0, 1'b1, 1'b0, 2'b10, 6'h30, 32'h0);
        n = 0;
        forever begin
            @(negedge clk);
            if (m0_ready || n > 20) break;
            n++;
            @(posedge clk); #1;
        end
        check("abort_accept", n <= 20, 1);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 2'b10, 6'h30, 32'h0);
        repeat (2) begin @(posedge clk); #1; end
        check("abort_rd_strobe", data_read_n, 2'b10);
        #2 rst = 1'b1;
        #1;
        check("abort_strobe_idle", data_read_n, 2'b11);
        check("abort_address", address, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        respcnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (m0_resp_valid || m1_resp_valid) respcnt++;
        end
        @(posedge clk); #1;
        check("abort_no_resp", respcnt, 0);
        run_and_check("post_abort", 1, 1'b0, 2'b00, 6'h10, 32'h0, 32'h0000_00F0, 1'b0, 5, 0, 4);

        // Randomized traffic from both masters.
        for (int i = 0; i < 64; i++) begin mem[i] = $urandom; rd_wait[i] = $urandom_range(0, 9); end
        fork
            for (int i = 0; i < 20; i++) begin
                bit wr; logic [1:0] txn; logic [5:0] a; logic [31:0] wd;
                logic [31:0] er; bit ee; int el, ew, erc;
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                wr = 1'($urandom_range(0, 1));
                txn = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
                a = 6'($urandom_range(0, 63));
                wd = $urandom;
                model(wr, txn, a, er, ee, el, ew, erc);
                run_and_check("rand_m0", 0, wr, txn, a, wd, er, ee, el, ew, erc);
            end
            for (int j = 0; j < 20; j++) begin
                bit wr; logic [1:0] txn; logic [5:0] a; logic [31:0] wd;
                logic [31:0] er; bit ee; int el, ew, erc;
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                wr = 1'($urandom_range(0, 1));
                txn = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
                a = 6'($urandom_range(0, 63));
                wd = $urandom;
                model(wr, txn, a, er, ee, el, ew, erc);
                run_and_check("rand_m1", 1, wr, txn, a, wd, er, ee, el, ew, erc);
            end
        join

        for (int i = 0; i < g_act.size(); i++)
            check($sformatf("grant%0d", i), g_act[i], g_exp[i]);
        check("no_dual_strobe", overlap, 0);
        check("no_dual_ready", dual_rdy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
